da_bus_rx: RTL and testbench



---
 rtl/da_bus_rx.sv | 157 +++++++++++++++
 tb/tb_da_bus_rx.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/da_bus_rx.sv
// Receiver for the parallel DAC write bus: decodes cs/wr strobes, checks protocol,
// and queues accepted samples onto a valid/ready stream with single-cycle error pulses.
module da_bus_rx #(
  parameter int MIN_WR_LOW = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        wr,
  input  logic [7:0]  din,
  input  logic        dout_rdy,
  output logic [7:0]  dout,
  output logic        dout_vld,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] wr_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]  MIN_LOW_C = 4'(MIN_WR_LOW);

  localparam logic [1:0] ERR_ABORT    = 2'd1;
  localparam logic [1:0] ERR_UNSTABLE = 2'd2;
  localparam logic [1:0] ERR_OVF      = 2'd3;

  typedef enum logic [1:0] {IDLE, SEL, WRL} state_t;

  state_t      state;
  logic        cs_r, wr_r;
  logic [7:0]  din_r;
  logic [7:0]  hold;
  logic [3:0]  low_cnt;
  logic        bad;

  logic        push_req, eval_err;
  logic [1:0]  eval_code;
  logic        pop, full, push_ok, ovf;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;

  // Idle-high reset values keep the first sampled cycle from looking like a strobe edge.
  // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_r  <= 1'b1;
      wr_r  <= 1'b1;
      din_r <= 8'h00;
    end else begin
      cs_r  <= cs;
      wr_r  <= wr;
      din_r <= din;
    end
  end

  // Write evaluation happens in the cycle WRL sees the strobe end; cs rising wins (abort).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    push_req  = 1'b0;
    eval_err  = 1'b0;
    eval_code = 2'd0;
    if (state == WRL) begin
      if (cs_r) begin
        eval_err  = 1'b1;
        eval_code = ERR_ABORT;
      end else if (wr_r) begin
        if (low_cnt < MIN_LOW_C) begin
          eval_err  = 1'b1;
          eval_code = ERR_ABORT;
        end else if (bad) begin
          eval_err  = 1'b1;
          eval_code = ERR_UNSTABLE;
        end else begin
          push_req = 1'b1;
        end
      end
    end
  end

  assign pop     = dout_vld & dout_rdy;
  assign full    = (count == DEPTH_C);
  assign push_ok = push_req & (~full | pop);
  assign ovf     = push_req & ~push_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      hold     <= 8'h00;
      low_cnt  <= 4'd0;
      bad      <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'd0;
    end else begin
      err <= eval_err | ovf;
      if (eval_err)
        err_code <= eval_code;
      else if (ovf)
        err_code <= ERR_OVF;

      case (state)
        IDLE: if (!cs_r) state <= SEL;
        SEL: begin
          if (cs_r) begin
            state <= IDLE;
          end else if (!wr_r) begin
            state   <= WRL;
            hold    <= din_r;
            low_cnt <= 4'd1;
          end
        end
        WRL: begin
          if (cs_r) begin
            state <= IDLE;
            bad   <= 1'b0;
          end else if (wr_r) begin
            state <= SEL;
            bad   <= 1'b0;
          end else begin
            if (low_cnt != 4'd15) low_cnt <= low_cnt + 4'd1;
            if (din_r != hold) bad <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the storage is reset too, because dout reads it directly and must show 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_cnt <= 16'h0000;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= hold;
        wr_ptr      <= wr_ptr + 1'b1;
        wr_cnt      <= wr_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout     = mem[rd_ptr];
  assign dout_vld = (count != '0);

endmodule

// File: tb/tb_da_bus_rx.sv
// Scoreboard bench for da_bus_rx: stimulus pushes expected samples/error codes,
// negedge monitors pop and compare whenever a DUT transfers or pulses err.
module tb_da_bus_rx;

  logic        clk = 1'b0;
  logic        rst_n, rst3_n;
  logic        cs, wr, dout_rdy;
  logic [7:0]  din;

  logic [7:0]  dout, dout3;
  logic        dout_vld, dout_vld3, err, err3;
  logic [1:0]  err_code, err_code3;
  logic [15:0] wr_cnt, wr_cnt3;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_cnt  = 0;
  int exp_cnt3 = 0;

  logic [7:0] exp_d[$];
  logic [1:0] exp_e[$];
  logic [7:0] exp_d3[$];
  logic [1:0] exp_e3[$];

  always #5 clk = ~clk;

  da_bus_rx #(.MIN_WR_LOW(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .din(din), .dout_rdy(dout_rdy),
    .dout(dout), .dout_vld(dout_vld), .err(err), .err_code(err_code), .wr_cnt(wr_cnt)
  );

  // Second instance exercises the longer minimum strobe; held in reset outside its test.
  da_bus_rx #(.MIN_WR_LOW(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst_n(rst3_n), .cs(cs), .wr(wr), .din(din), .dout_rdy(dout_rdy),
    .dout(dout3), .dout_vld(dout_vld3), .err(err3), .err_code(err_code3), .wr_cnt(wr_cnt3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (dout_vld && dout_rdy) begin
      if (exp_d.size() == 0) begin
        n_checks++;
        $display("FAIL dout_unexpected: got %0h expected no transfer", dout);
      end else check("dout", dout, exp_d.pop_front());
    end
    if (err) begin
      if (exp_e.size() == 0) begin
        n_checks++;
        $display("FAIL err_unexpected: got code %0d expected no err", err_code);
      end else check("err_code", err_code, exp_e.pop_front());
    end
  end

  always @(negedge clk) begin
    if (dout_vld3 && dout_rdy) begin
      if (exp_d3.size() == 0) begin
        n_checks++;
        $display("FAIL dout3_unexpected: got %0h expected no transfer", dout3);
      end else check("dout3", dout3, exp_d3.pop_front());
    end
    if (err3) begin
      if (exp_e3.size() == 0) begin
        n_checks++;
        $display("FAIL err3_unexpected: got code %0d expected no err", err_code3);
      end else check("err_code3", err_code3, exp_e3.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic select_bus();
    cs = 1'b0;
    tick(2);
  endtask

  task automatic deselect_bus();
    cs = 1'b1;
    tick(2);
  endtask

  task automatic write(input logic [7:0] d, input int n);
    din = d;
    wr  = 1'b0;
    tick(n);
    wr  = 1'b1;
    tick(1);
  endtask

  task automatic expect_push(input logic [7:0] d);
    exp_d.push_back(d);
    exp_cnt++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    exp_cnt = 0;
    tick(1);
  endtask

  task automatic settle(input string name);
    tick(6);
    check({name, "_data_left"}, exp_d.size(), 0);
    check({name, "_err_left"}, exp_e.size(), 0);
    check({name, "_wr_cnt"}, wr_cnt, exp_cnt);
  endtask

  initial begin
    rst_n = 1'b0; rst3_n = 1'b0;
    cs = 1'b1; wr = 1'b1; din = 8'h00; dout_rdy = 1'b0;
    #3;
    check("rst_dout", dout, 0);
    check("rst_dout_vld", dout_vld, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    check("rst_wr_cnt", wr_cnt, 0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Single write, drained immediately
    dout_rdy = 1'b1;
    expect_push(8'h5A);
    select_bus();
    write(8'h5A, 2);
    deselect_bus();
    settle("single");

    // Burst of six 1-cycle strobes into a stalled 4-deep FIFO
    do_reset();
    dout_rdy = 1'b0;
    select_bus();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) expect_push(8'(i));
      else exp_e.push_back(2'd3);
      write(8'(i), 1);
    end
    deselect_bus();
    tick(2);
    check("burst_wr_cnt", wr_cnt, 4);
    check("burst_head", dout, 8'h01);
    check("burst_err_code_held", err_code, 3);
    dout_rdy = 1'b1;
    tick(4);
    check("burst_drained_vld", dout_vld, 0);
    settle("burst");

    // Unstable data during a 3-cycle low phase
    exp_e.push_back(2'd2);
    select_bus();
    din = 8'h10; wr = 1'b0;
    tick(1);
    din = 8'h11;
    tick(2);
    wr = 1'b1;
    tick(1);
    deselect_bus();
    settle("unstable");

    // cs rises while wr is still low
    exp_e.push_back(2'd1);
    select_bus();
    din = 8'h77; wr = 1'b0;
    tick(2);
    cs = 1'b1;
    tick(2);
    wr = 1'b1;
    tick(2);
    settle("abort");

    // Strobe while deselected: ignored entirely
    din = 8'h99; wr = 1'b0;
    tick(2);
    wr = 1'b1;
    tick(2);
    settle("deselected");

    // wr and cs rise on the same edge
    exp_e.push_back(2'd1);
    select_bus();
    din = 8'h66; wr = 1'b0;
    tick(2);
    wr = 1'b1; cs = 1'b1;
    tick(2);
    settle("simul_rise");

    // MIN_WR_LOW=3 instance: 2-cycle strobe is short, 3-cycle accepted
    rst3_n = 1'b1;
    tick(1);
    exp_e3.push_back(2'd1);
    exp_d3.push_back(8'h44);
    exp_cnt3++;
    expect_push(8'h33);
    expect_push(8'h44);
    select_bus();
    write(8'h33, 2);
    write(8'h44, 3);
    deselect_bus();
    settle("short");
    check("short_data3_left", exp_d3.size(), 0);
    check("short_err3_left", exp_e3.size(), 0);
    check("short_wr_cnt3", wr_cnt3, exp_cnt3);
    rst3_n = 1'b0;

    // Reset with two entries queued and a write in progress
    dout_rdy = 1'b0;
    select_bus();
    write(8'h21, 1);
    write(8'h22, 1);
    din = 8'h23; wr = 1'b0;
    tick(1);
    check("pre_rst_wr_cnt", wr_cnt, exp_cnt + 2);
    rst_n = 1'b0;
    #2;
    check("mid_rst_dout", dout, 0);
    check("mid_rst_dout_vld", dout_vld, 0);
    check("mid_rst_err", err, 0);
    check("mid_rst_err_code", err_code, 0);
    check("mid_rst_wr_cnt", wr_cnt, 0);
    exp_d.delete();
    exp_e.delete();
    exp_cnt = 0;
    wr = 1'b1; cs = 1'b1;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    expect_push(8'hA5);
    select_bus();
    write(8'hA5, 2);
    deselect_bus();
    check("post_rst_dout", dout, 8'hA5);
    check("post_rst_vld", dout_vld, 1);
    check("post_rst_wr_cnt", wr_cnt, 1);
    dout_rdy = 1'b1;
    settle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
